// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared PS/2 host transmitter definitions
//
// Contents: FSM state encodings, PS/2 frame length, microsecond-to-cycle
// conversion and the frame-word builder used when a command byte is loaded.
// These definitions are shared with the keyboard receive path.

package ps2_host_tx_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RTS      = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_ACK      = 3'd4;
    localparam logic [2:0] ST_ACK_WAIT = 3'd5;

    // start + 8 data + parity + stop; the 11th device clock carries the ack
    localparam int PS2_FRAME_LEN = 11;

    function automatic int us_to_cyc(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    // {stop, odd parity, data}; bit 0 goes on the wire first
    function automatic logic [9:0] frame_word(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - PS/2 clock synchroniser, glitch filter and fall detector
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   ps2c_in    in   raw PS/2 clock line
//   level      out  filtered clock level
//   fall_edge  out  one-cycle pulse on a filtered 1->0 transition
//
// The filtered level only changes once FILTER_LEN consecutive synchronised
// samples agree. FILTER_LEN must be at least 2.

module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2c_in,
    output logic level,
    output logic fall_edge
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] shreg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '1;
            shreg <= '1;
            level <= 1'b1;
        end else begin
            sync  <= {sync[0], ps2c_in};
            shreg <= {shreg[FILTER_LEN-2:0], sync[1]};
            if (shreg == '0) begin
                level <= 1'b0;
            end else if (&shreg) begin
                level <= 1'b1;
            end
        end
    end

    // Combinational so the pulse appears in the same cycle the window fills
    assign fall_edge = level && (shreg == '0);

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Ports:
//   clk           in     system clock
//   reset_n       in     asynchronous active-low reset
//   wr_ps2        in     strobe: load din and start a transfer (only while tx_idle)
//   din[7:0]      in     command byte, sent LSB first
//   ps2c          inout  PS/2 clock, open-drain (driven 0 or released)
//   ps2d          inout  PS/2 data, open-drain (driven 0 or released)
//   tx_idle       out    ready for wr_ps2; receive path may use the bus
//   tx_done_tick  out    pulse: byte sent and ack received
//   tx_err_tick   out    pulse: missing ack or timeout, transfer aborted

module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int RTS_US      = 100,
    parameter int TIMEOUT_US  = 15_000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int RTS_CYC = us_to_cyc(CLK_FREQ_HZ, RTS_US);
    localparam int TO_CYC  = us_to_cyc(CLK_FREQ_HZ, TIMEOUT_US);
    localparam int T_MAX   = (TO_CYC > RTS_CYC) ? TO_CYC : RTS_CYC;
    localparam int TW      = $clog2(T_MAX + 1);
    // edge count at which the stop bit has just been presented
    localparam logic [3:0] LAST_BIT_CNT = 4'(PS2_FRAME_LEN - 2);

    logic [2:0]    state;
    logic [9:0]    tx_sr;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic          c_low;
    logic          d_low;
    logic [1:0]    d_sync;
    logic          c_level;
    logic          fall_edge;
    logic          timeout;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2c_in   (ps2c),
        .level     (c_level),
        .fall_edge (fall_edge)
    );

    // timer holds cycles elapsed since the last device edge (the edge cycle
    // itself counts as 1), so the abort lands exactly TO_CYC cycles later
    assign timeout = (timer == TW'(TO_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            tx_sr        <= '0;
            bit_cnt      <= '0;
            timer        <= '0;
            c_low        <= 1'b0;
            d_low        <= 1'b0;
            d_sync       <= '1;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
            d_sync       <= {d_sync[0], ps2d};

            case (state)
                ST_IDLE: begin
                    c_low <= 1'b0;
                    d_low <= 1'b0;
                    if (wr_ps2) begin
                        tx_sr   <= frame_word(din);
                        bit_cnt <= '0;
                        timer   <= '0;
                        c_low   <= 1'b1;
                        state   <= ST_RTS;
                    end
                end

                ST_RTS: begin
                    timer <= timer + 1'b1;
                    if (timer == TW'(RTS_CYC - 1)) begin
                        d_low <= 1'b1;
                    end
                    // start bit has been on the bus for one cycle: hand the clock over
                    if (timer == TW'(RTS_CYC)) begin
                        c_low <= 1'b0;
                        timer <= '0;
                        state <= ST_START;
                    end
                end

                ST_START, ST_DATA: begin
                    if (fall_edge) begin
                        d_low   <= ~tx_sr[0];
                        tx_sr   <= {1'b0, tx_sr[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        timer   <= TW'(1);
                        if (state == ST_START) begin
                            state <= ST_DATA;
                        end else if (bit_cnt == LAST_BIT_CNT) begin
                            state <= ST_ACK;
                        end
                    end else if (timeout) begin
                        c_low       <= 1'b0;
                        d_low       <= 1'b0;
                        tx_err_tick <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_ACK: begin
                    if (fall_edge) begin
                        timer <= TW'(1);
                        if (!d_sync[1]) begin
                            state <= ST_ACK_WAIT;
                        end else begin
                            tx_err_tick <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        c_low       <= 1'b0;
                        d_low       <= 1'b0;
                        tx_err_tick <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_ACK_WAIT: begin
                    if (c_level && d_sync[1]) begin
                        tx_done_tick <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (fall_edge) begin
                        timer <= TW'(1);
                    end else if (timeout) begin
                        c_low       <= 1'b0;
                        d_low       <= 1'b0;
                        tx_err_tick <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    c_low <= 1'b0;
                    d_low <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_idle = (state == ST_IDLE);

    assign ps2c = c_low ? 1'b0 : 1'bz;
    assign ps2d = d_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int CLK_HZ  = 4_000_000;
    localparam int RTS_US  = 100;
    localparam int TO_US   = 200;
    localparam int FLEN    = 8;
    localparam int CPU     = CLK_HZ / 1_000_000;
    localparam int RTS_CYC = CPU * RTS_US;
    localparam int TO_CYC  = CPU * TO_US;
    localparam int HALF    = CPU * 20;        // 40us device clock period
    // bus fall before posedge n -> host sees the edge in the cycle starting at posedge n+LAT
    localparam int LAT     = 2 + FLEN - 1;

    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_STOP   = 2;
    localparam int M_STROBE = 3;
    localparam int M_RESET  = 4;
    localparam int M_GLITCH = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;
    logic       bfm_c_low = 1'b0;
    logic       bfm_d_low = 1'b0;

    assign ps2c = bfm_c_low ? 1'b0 : 1'bz;
    assign ps2d = bfm_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_host_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .RTS_US      (RTS_US),
        .TIMEOUT_US  (TO_US),
        .FILTER_LEN  (FLEN)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err_tick  (tx_err_tick)
    );

    always #125 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_err_tick) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame as the device should see it on its rising edges: d0..d7, parity, stop
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic run_frame(input logic [7:0] b, input int mode);
        logic [9:0] exp_bits;
        logic [9:0] got_bits;
        int low_len;
        int d0;
        int e0;
        int fall_cyc;
        int w;
        exp_bits = model_frame(b);
        got_bits = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        fall_cyc = 0;

        @(negedge clk);
        din = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("busy_after_load", int'(tx_idle), 0);

        low_len = 0;
        while (ps2c === 1'b0 && low_len < RTS_CYC + 100) begin
            @(negedge clk);
            low_len++;
        end
        check("rts_hold_len", int'(low_len >= RTS_CYC && low_len < RTS_CYC + 100), 1);
        check("start_bit", int'(ps2d), 0);
        repeat (20) @(negedge clk);

        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode != M_NOACK) bfm_d_low = 1'b1;
            bfm_c_low = 1'b1;
            fall_cyc = cyc + 1;
            repeat (HALF) @(negedge clk);
            if (mode == M_STROBE && k == 4) begin
                din = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                din = b;
            end
            bfm_c_low = 1'b0;
            if (k <= 10) got_bits[k-1] = ps2d;
            if (k == 11) bfm_d_low = 1'b0;
            if (mode == M_STOP && k == 4) break;
            if (mode == M_RESET && k == 5) begin
                repeat (10) @(negedge clk);
                check("data_low_before_reset", int'(ps2d), 0);
                reset_n = 1'b0;
                #1;
                check("reset_ps2c_rel", int'(ps2c), 1);
                check("reset_ps2d_rel", int'(ps2d), 1);
                check("reset_idle", int'(tx_idle), 1);
                @(negedge clk);
                reset_n = 1'b1;
                repeat (5) @(negedge clk);
                break;
            end
            if (mode == M_GLITCH && k == 3) begin
                repeat (20) @(negedge clk);
                bfm_c_low = 1'b1;
                repeat (3) @(negedge clk);
                bfm_c_low = 1'b0;
                repeat (HALF - 23) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end

        if (mode == M_STOP) begin
            w = 0;
            while (err_cnt == e0 && w < TO_CYC + 100) begin
                @(negedge clk);
                w++;
            end
            repeat (2) @(negedge clk);
            check("timeout_err_count", err_cnt - e0, 1);
            check("timeout_cycle", err_cyc, fall_cyc + LAT + TO_CYC);
            check("timeout_bits_before", int'(got_bits[3:0]), int'(exp_bits[3:0]));
            check("timeout_no_done", done_cnt - d0, 0);
        end else if (mode == M_RESET) begin
            check("reset_no_ticks", (done_cnt - d0) + (err_cnt - e0), 0);
        end else begin
            repeat (20) @(negedge clk);
            check("frame_bits", int'(got_bits), int'(exp_bits));
            check("done_count", done_cnt - d0, (mode == M_NOACK) ? 0 : 1);
            check("err_count", err_cnt - e0, (mode == M_NOACK) ? 1 : 0);
        end
        check("idle_after", int'(tx_idle), 1);
        check("ps2c_released", int'(ps2c), 1);
        check("ps2d_released", int'(ps2d), 1);
    endtask

    initial begin
        #(90000 * 250);
        $display("FAIL watchdog: simulation exceeded cycle budget, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_idle", int'(tx_idle), 1);
        check("reset_done_tick", int'(tx_done_tick), 0);
        check("reset_err_tick", int'(tx_err_tick), 0);
        check("reset_ps2c", int'(ps2c), 1);
        check("reset_ps2d", int'(ps2d), 1);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        run_frame(8'hED, M_NORMAL);
        run_frame(8'hF4, M_NORMAL);
        run_frame(8'h00, M_NORMAL);
        for (int i = 0; i < 3; i++) run_frame(8'($urandom), M_NORMAL);
        run_frame(8'($urandom), M_NOACK);
        run_frame(8'hFF, M_STOP);
        run_frame(8'hC6, M_STROBE);
        run_frame(8'h00, M_RESET);
        run_frame(8'($urandom), M_NORMAL);
        run_frame(8'h5A, M_GLITCH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
